saturn_run_ctrl: RTL and testbench
==================================

# saturn_run_ctrl

Board-level run controller between the FPGA pins and `saturn_bus`, generalising the fixed 1/8 s stepper into a parametrised block. Generates the bus clock-enable in three modes (timed run, single-step, full speed), and debounces the board buttons. Also sequences the bus reset on tick boundaries and multiplexes status and output characters onto the LEDs.

## Interface
Parameters:
- `DIV_PERIOD`, 3_125_000: `i_clk` cycles per tick, ≥2; 1/8 s at 25 MHz.
- `DIV_W`, 26: tick counter width; DIV_PERIOD-1 < 2^DIV_W.
- `DEB_CYCLES`, 250_000: stable cycles needed to accept a button level, ≥1.
- `DEB_W`, 18: debounce counter width.
- `LED_W`, 8: LED width, ≥2.

Ports:
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  one clock; reset is synchronous and active-high.
- `i_btn_reset`  in  1  raw bus-reset button, asynchronous to `i_clk`.
- `i_btn_step`  in  1  raw step button.
- `i_btn_mode`  in  1  raw mode button.
- `i_halt`  in  1  halt from `saturn_bus`.
- `i_cycle_ctr`  in  32  bus cycle counter.
- `i_char`  in  8  bus character-to-send.
- `o_clk_en`  out  1  bus clock enable, single-cycle pulses.
- `o_bus_reset`  out  1  reset to `saturn_bus`.
- `o_mode`  out  2  current mode: 0 RUN, 1 STEP, 2 FAST.
- `o_led`  out  LED_W  LED drive.

## Operation
- Buttons: each passes a 2-flop synchroniser, then a debouncer. The debounce counter clears on any change of the synchronised level. The output level changes after DEB_CYCLES consecutive equal samples. A rise pulse is one cycle wide and coincides with that level change.
- Tick counter: counts 0..DIV_PERIOD-1, then wraps to 0. `tick` is high for the cycle in which the count equals DIV_PERIOD-1. The counter runs in all states.
- FSM states: BUS_RST, RUN, STEP, FAST, HALTED.
- BUS_RST: `o_bus_reset`=1. `o_clk_en` pulses on every tick; `i_halt` is ignored. On a tick with the debounced reset button low, go to the state held in the mode register.
- Any state other than BUS_RST: debounced reset button high → BUS_RST.
- RUN: `o_clk_en` pulses on each tick.
- STEP: `o_clk_en` pulses once per step rise.
- FAST: `o_clk_en`=1 on every cycle.
- RUN, STEP or FAST with `i_halt`=1 → HALTED. No `o_clk_en` in HALTED. HALTED exits only through BUS_RST.
- Mode rise: advances the mode register RUN→STEP→FAST→RUN. In RUN, STEP or FAST the FSM switches state in the same cycle. In BUS_RST or HALTED only the register changes.
- Simultaneous mode rise and step rise: mode wins and the step is dropped. Simultaneous halt and mode rise: halt wins, and the mode register still advances.
- Display phase bit toggles on each tick. Phase 0 shows {halt, i_cycle_ctr[LED_W-2:0]}. Phase 1 shows i_char[LED_W-1:0] when not halted, otherwise phase-0 content. When LED_W>8, the unused upper bits of the char are zero.

## Timing
- Reset values: FSM=BUS_RST, mode register=RUN, `o_bus_reset`=1, `o_clk_en`=0, `o_led`=1 (only bit 0 set), tick counter=0, phase=0, debouncers at level 0 with no pulses.
- All outputs are registered.
- `o_clk_en` is asserted in the cycle after `tick` or after the step rise. In FAST it is asserted in the cycle after entry.
- Button latency from raw pin to debounced level is 2 + DEB_CYCLES cycles.
- `o_bus_reset` falls in the cycle after the qualifying tick. `o_led` updates in the cycle after a phase change.
- `i_halt` is sampled every cycle. When `i_halt` rises, no `o_clk_en` pulse is issued from the following cycle onward.
- `i_reset` mid-operation returns every register to its reset value on the next edge, including debounce state.

## Structure
- Shared package `saturn_board_pkg` holds:
  - the mode encoding (RUN/STEP/FAST localparams);
  - the FSM state encoding;
  - default constants `DIV_PERIOD_8HZ`, `DEB_10MS` for a 25 MHz clock.
- Sub-module `saturn_debounce` (parameters DEB_CYCLES, DEB_W; outputs level and rise), instantiated three times.

## Test plan
Bench parameters: DIV_PERIOD=4, DEB_CYCLES=3, LED_W=8.
- Release from reset with all buttons low → `o_bus_reset` falls one cycle after the first tick, then `o_clk_en` pulses every 4 cycles; `o_mode`=0.
- Mode press held 5 cycles → after 2+3 cycles `o_mode`=1 and `o_clk_en` stays 0. Two step presses → exactly two `o_clk_en` pulses, each one cycle after its rise. A 2-cycle glitch on the step button → no pulse.
- Two further mode presses → FAST, `o_clk_en` continuously 1. A third press → RUN, `o_clk_en` at the 4-cycle rate.
- `i_halt`=1 in RUN → no `o_clk_en` from the next cycle on, and LED bit 7=1 in both phases. Reset-button press → BUS_RST with pulses on ticks. Release with `i_halt`=0 → RUN resumes.
- `i_char`=8'h41, `i_cycle_ctr`=32'h85, no halt → `o_led` alternates between 8'h05 and 8'h41 every 4 cycles.
- Mode and step rises in the same cycle while in STEP → mode becomes FAST and no extra single pulse is issued. Assert `i_reset` mid-FAST → next cycle `o_clk_en`=0, `o_bus_reset`=1, `o_mode`=0, `o_led`=8'h01.

Source files
------------

// File: rtl/saturn_board_pkg.sv
// Shared encodings and 25 MHz default constants for the Saturn board run controller.
package saturn_board_pkg;

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_STEP = 2'd1;
  localparam logic [1:0] MODE_FAST = 2'd2;

  typedef enum logic [2:0] {
    ST_BUS_RST = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_FAST    = 3'd3,
    ST_HALTED  = 3'd4
  } run_state_t;

  localparam int DIV_PERIOD_8HZ = 3_125_000;
  localparam int DEB_10MS       = 250_000;

  // Mode button cycles RUN -> STEP -> FAST -> RUN.
  function automatic logic [1:0] mode_advance(input logic [1:0] m);
    case (m)
      MODE_RUN:  return MODE_STEP;
      MODE_STEP: return MODE_FAST;
      default:   return MODE_RUN;
    endcase
  endfunction

  function automatic run_state_t mode_state(input logic [1:0] m);
    case (m)
      MODE_STEP: return ST_STEP;
      MODE_FAST: return ST_FAST;
      default:   return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/saturn_debounce.sv
// Button conditioner: 2-flop synchroniser, then a level accepted after DEB_CYCLES stable samples.
module saturn_debounce #(
  parameter int DEB_CYCLES = 250_000,
  parameter int DEB_W      = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1, sync2;
  logic [DEB_W-1:0] cnt;

  // cnt holds how many consecutive samples have disagreed with the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/saturn_run_ctrl.sv
// Board run controller: bus clock-enable generation (RUN/STEP/FAST), bus reset sequencing,
// button conditioning and LED multiplexing for saturn_bus.
module saturn_run_ctrl
  import saturn_board_pkg::*;
#(
  parameter int DIV_PERIOD = DIV_PERIOD_8HZ,
  parameter int DIV_W      = 26,
  parameter int DEB_CYCLES = DEB_10MS,
  parameter int DEB_W      = 18,
  parameter int LED_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_btn_reset,
  input  logic             i_btn_step,
  input  logic             i_btn_mode,
  input  logic             i_halt,
  input  logic [31:0]      i_cycle_ctr,
  input  logic [7:0]       i_char,
  output logic             o_clk_en,
  output logic             o_bus_reset,
  output logic [1:0]       o_mode,
  output logic [LED_W-1:0] o_led
);

  localparam int BTN_RST  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_MODE = 2;
  localparam int CHAR_W   = (LED_W < 8) ? LED_W : 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_PERIOD - 1);

  logic [2:0] btn_level, btn_rise;

  saturn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_deb [2:0] (
    .clk   (i_clk),
    .reset (i_reset),
    .btn   ({i_btn_mode, i_btn_step, i_btn_reset}),
    .level (btn_level),
    .rise  (btn_rise)
  );

  logic rst_level, step_rise, mode_rise;
  assign rst_level = btn_level[BTN_RST];
  assign step_rise = btn_rise[BTN_STEP];
  assign mode_rise = btn_rise[BTN_MODE];

  // Reset-button rise, upper counter bits and unused char bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{btn_rise[BTN_RST], btn_level[BTN_STEP], btn_level[BTN_MODE],
                         i_cycle_ctr, i_char};

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  assign tick = (div_cnt == DIV_LAST);

  run_state_t       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             phase_q;
  logic             clk_en_d, bus_reset_d;
  logic [LED_W-1:0] led_status, led_char, led_d;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_rise ? mode_advance(mode_q) : mode_q;
    clk_en_d = 1'b0;
    case (state_q)
      ST_BUS_RST: begin
        clk_en_d = tick;
        if (tick && !rst_level) state_d = mode_state(mode_d);
      end
      ST_HALTED: begin
        if (rst_level) state_d = ST_BUS_RST;
      end
      ST_RUN, ST_STEP, ST_FAST: begin
        // Priority: reset button, then halt, then mode change; a switching cycle issues no enable.
        if (rst_level) begin
          state_d = ST_BUS_RST;
        end else if (i_halt) begin
          state_d = ST_HALTED;
        end else if (mode_rise) begin
          state_d = mode_state(mode_d);
        end else begin
          case (state_q)
            ST_RUN:  clk_en_d = tick;
            ST_STEP: clk_en_d = step_rise;
            default: clk_en_d = 1'b1;
          endcase
        end
      end
      default: state_d = ST_BUS_RST;
    endcase
    bus_reset_d = (state_d == ST_BUS_RST);
  end

  always_comb begin
    led_status                 = '0;
    led_status[LED_W-1]        = i_halt;
    led_status[LED_W-2:0]      = i_cycle_ctr[LED_W-2:0];
    led_char                   = '0;
    led_char[CHAR_W-1:0]       = i_char[CHAR_W-1:0];
    led_d = (phase_q && !i_halt) ? led_char : led_status;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt     <= '0;
      state_q     <= ST_BUS_RST;
      mode_q      <= MODE_RUN;
      phase_q     <= 1'b0;
      o_clk_en    <= 1'b0;
      o_bus_reset <= 1'b1;
      o_led       <= LED_W'(1);
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      state_q     <= state_d;
      mode_q      <= mode_d;
      phase_q     <= phase_q ^ tick;
      o_clk_en    <= clk_en_d;
      o_bus_reset <= bus_reset_d;
      o_led       <= led_d;
    end
  end

  assign o_mode = mode_q;

endmodule

// File: tb/tb_saturn_run_ctrl.sv
// Scoreboard bench for saturn_run_ctrl: behavioural model pushes expected outputs, monitor compares.
module tb_saturn_run_ctrl;

  localparam int P  = 4;
  localparam int D  = 3;
  localparam int LW = 8;
  localparam int M_BUS  = 3;
  localparam int M_HALT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset   = 1'b1;
  logic          btn_reset = 1'b0;
  logic          btn_step  = 1'b0;
  logic          btn_mode  = 1'b0;
  logic          halt      = 1'b0;
  logic [31:0]   ctr       = 32'h85;
  logic [7:0]    chr       = 8'h41;
  logic          clk_en, bus_reset;
  logic [1:0]    mode;
  logic [LW-1:0] led;

  saturn_run_ctrl #(
    .DIV_PERIOD (P),
    .DIV_W      (26),
    .DEB_CYCLES (D),
    .DEB_W      (18),
    .LED_W      (LW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_btn_reset (btn_reset),
    .i_btn_step  (btn_step),
    .i_btn_mode  (btn_mode),
    .i_halt      (halt),
    .i_cycle_ctr (ctr),
    .i_char      (chr),
    .o_clk_en    (clk_en),
    .o_bus_reset (bus_reset),
    .o_mode      (mode),
    .o_led       (led)
  );

  typedef struct packed {
    logic          en;
    logic          br;
    logic [1:0]    md;
    logic [LW-1:0] led;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   en_seen  = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endfunction

  // Reference model: modes 0..2 double as RUN/STEP/FAST states, plus BUS and HALT.
  int            m_state = M_BUS, m_mode = 0, m_age = 0, nst = 0, nmode = 0;
  bit            m_phase = 0;
  bit            m_lvl[3], m_rise[3], m_s1[3], m_s2[3];
  logic [D-1:0]  m_hist[3];
  int            m_fill[3];
  bit            tick, en;
  logic [2:0]    raw;
  logic [LW-1:0] status;
  exp_t          e;

  initial forever begin
    @(posedge clk);
    if (i_reset) begin
      m_state = M_BUS; m_mode = 0; m_age = 0; m_phase = 0;
      for (int b = 0; b < 3; b++) begin
        m_lvl[b] = 0; m_rise[b] = 0; m_s1[b] = 0; m_s2[b] = 0; m_hist[b] = '0; m_fill[b] = 0;
      end
      e.en = 1'b0; e.br = 1'b1; e.md = 2'd0; e.led = 8'h01;
    end else begin
      tick  = ((m_age % P) == P - 1);
      nmode = m_rise[2] ? (m_mode + 1) % 3 : m_mode;
      en    = 0;
      nst   = m_state;
      if (m_state == M_BUS) begin
        en = tick;
        if (tick && !m_lvl[0]) nst = nmode;
      end else if (m_state == M_HALT) begin
        if (m_lvl[0]) nst = M_BUS;
      end else if (m_lvl[0]) nst = M_BUS;
      else if (halt)         nst = M_HALT;
      else if (m_rise[2])    nst = nmode;
      else if (m_state == 0) en = tick;
      else if (m_state == 1) en = m_rise[1];
      else                   en = 1;
      status = {halt, ctr[6:0]};
      e.led  = (m_phase && !halt) ? chr : status;
      e.en   = en;
      e.br   = (nst == M_BUS);
      e.md   = nmode[1:0];
      m_state = nst; m_mode = nmode; m_phase = m_phase ^ tick; m_age++;
      raw = {btn_mode, btn_step, btn_reset};
      for (int b = 0; b < 3; b++) begin
        m_rise[b] = 0;
        m_hist[b] = {m_hist[b][D-2:0], m_s2[b]};
        m_fill[b]++;
        if (m_fill[b] >= D && m_hist[b] == {D{~m_lvl[b]}}) begin
          m_lvl[b]  = ~m_lvl[b];
          m_rise[b] = m_lvl[b];
          m_fill[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
    sb.push_back(e);
  end

  exp_t got_e;
  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      got_e = sb.pop_front();
      check("clk_en",    clk_en,    got_e.en);
      check("bus_reset", bus_reset, got_e.br);
      check("mode",      mode,      got_e.md);
      check("led",       led,       got_e.led);
      if (clk_en === 1'b1) en_seen++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic win(input int n, output int cnt);
    int c0;
    #1 c0 = en_seen;
    repeat (n) @(negedge clk);
    #1 cnt = en_seen - c0;
  endtask

  int c, base, n05, n41;

  initial begin
    hold(2);
    i_reset = 1'b0;
    hold(12);
    #1 check("run_mode", mode, 0);
    check("bus_reset_released", bus_reset, 0);
    win(8, c); check("run_rate", c, 2);

    btn_mode = 1; hold(5); btn_mode = 0; hold(8);
    #1 check("step_mode", mode, 1);
    base = en_seen;
    btn_step = 1; hold(5); btn_step = 0; hold(6);
    btn_step = 1; hold(5); btn_step = 0; hold(6);
    #1 check("step_pulses", en_seen - base, 2);
    base = en_seen;
    btn_step = 1; hold(2); btn_step = 0; hold(8);
    #1 check("glitch_pulses", en_seen - base, 0);

    btn_mode = 1; hold(5); btn_mode = 0; hold(8);
    #1 check("fast_mode", mode, 2);
    win(8, c); check("fast_rate", c, 8);
    btn_mode = 1; hold(5); btn_mode = 0; hold(8);
    #1 check("back_to_run", mode, 0);
    win(8, c); check("run_rate2", c, 2);

    halt = 1;
    win(12, c); check("halt_no_en", c, 0);
    for (int k = 0; k < 8; k++) begin
      hold(1);
      #1 check("halt_led7", led[7], 1);
    end
    btn_reset = 1; hold(6);
    #1 check("bus_rst_enter", bus_reset, 1);
    win(8, c); check("bus_rst_rate", c, 2);
    btn_reset = 0; halt = 0; hold(12);
    #1 check("bus_rst_exit", bus_reset, 0);
    check("resume_mode", mode, 0);
    win(8, c); check("resume_rate", c, 2);

    n05 = 0; n41 = 0;
    for (int k = 0; k < 8; k++) begin
      hold(1);
      #1;
      if (led === 8'h05) n05++;
      if (led === 8'h41) n41++;
    end
    check("led_status_cnt", n05, 4);
    check("led_char_cnt", n41, 4);

    btn_mode = 1; hold(5); btn_mode = 0; hold(8);
    #1 check("step_again", mode, 1);
    btn_mode = 1; btn_step = 1; hold(5);
    btn_mode = 0; btn_step = 0; hold(1);
    #1 check("simul_no_step_en", clk_en, 0);
    check("simul_mode_fast", mode, 2);
    hold(1);
    #1 check("fast_after_simul", clk_en, 1);

    hold(4);
    i_reset = 1; hold(1);
    #1 check("mid_reset_en", clk_en, 0);
    check("mid_reset_br", bus_reset, 1);
    check("mid_reset_mode", mode, 0);
    check("mid_reset_led", led, 8'h01);
    i_reset = 0; hold(10);

    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0)  btn_mode  = ~btn_mode;
      if ($urandom_range(0, 3) == 0)  btn_step  = ~btn_step;
      if ($urandom_range(0, 29) == 0) btn_reset = ~btn_reset;
      if ($urandom_range(0, 39) == 0) halt      = ~halt;
      i_reset = ($urandom_range(0, 199) == 0);
      ctr = $urandom;
      chr = 8'($urandom_range(0, 255));
    end
    i_reset = 0;
    hold(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
